// File: rtl/sram_stream_loader.sv
// Write-side front end for the multi-bank SRAM array: turns a valid/ready word
// stream plus a (bank, base, length) command into registered per-bank write strobes.
module sram_stream_loader #(
    parameter int NUM_SRAMS  = 8,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 14
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [$clog2(NUM_SRAMS)-1:0]     bank_sel,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [LEN_WIDTH-1:0]             length,
    input  logic                             s_valid,
    input  logic [DATA_WIDTH-1:0]            s_data,
    input  logic                             s_last,
    output logic                             s_ready,
    output logic                             busy,
    output logic                             done,
    output logic                             err_last,
    output logic [NUM_SRAMS-1:0]             sram_en,
    output logic [NUM_SRAMS-1:0]             sram_we,
    output logic [NUM_SRAMS*ADDR_WIDTH-1:0]  sram_addr,
    output logic [NUM_SRAMS*DATA_WIDTH-1:0]  sram_data
);

    localparam int BANK_W = $clog2(NUM_SRAMS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = LEN_WIDTH'(0);

    logic [1:0]                        state_q, state_d;
    logic [BANK_W-1:0]                 bank_q, bank_d;
    logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
    logic [LEN_WIDTH-1:0]              cnt_q, cnt_d;
    logic                              err_q, err_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic                              ready_q, ready_d;
    logic [NUM_SRAMS-1:0]              en_q, en_d;
    logic [NUM_SRAMS*ADDR_WIDTH-1:0]   saddr_q, saddr_d;
    logic [NUM_SRAMS*DATA_WIDTH-1:0]   sdata_q, sdata_d;
    logic                              accept_s;
    logic                              final_s;

    // Next-state, counters, sticky error and the registered SRAM bus images
    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        // ready_q is only ever high in WRITE with words remaining
        accept_s = ready_q & s_valid;
        final_s  = (cnt_q == LEN_ONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bank_d  = bank_sel;
                    addr_d  = base_addr;
                    cnt_d   = length;
                    err_d   = 1'b0;
                    state_d = (length != LEN_ZERO) ? S_WRITE : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (accept_s) begin
                    cnt_d   = cnt_q - LEN_ONE;
                    addr_d  = addr_q + ADDR_ONE;
                    err_d   = err_q | (s_last ^ final_s);
                    state_d = final_s ? S_DONE : S_WRITE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        ready_d = (state_d == S_WRITE) && (cnt_d != LEN_ZERO);

        en_d    = '0;
        saddr_d = '0;
        sdata_d = '0;
        for (int i = 0; i < NUM_SRAMS; i++) begin
            en_d[i] = accept_s && (bank_q == BANK_W'(i));
            saddr_d[i*ADDR_WIDTH +: ADDR_WIDTH] = en_d[i] ? addr_q : '0;
            sdata_d[i*DATA_WIDTH +: DATA_WIDTH] = en_d[i] ? s_data : '0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            bank_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            en_q    <= '0;
            saddr_q <= '0;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            en_q    <= en_d;
            saddr_q <= saddr_d;
            sdata_q <= sdata_d;
        end
    end

    assign s_ready   = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_last  = err_q;
    assign sram_en   = en_q;
    assign sram_we   = en_q;
    assign sram_addr = saddr_q;
    assign sram_data = sdata_q;

endmodule

// File: tb/tb_sram_stream_loader.sv
// Self-checking bench for sram_stream_loader: table of transfers plus hand-written
// reset / start-while-busy sequences, checked cycle by cycle against a write scoreboard.
module tb_sram_stream_loader;

    localparam int NS = 8;
    localparam int AW = 13;
    localparam int DW = 64;
    localparam int LW = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        bank_sel;
    logic [AW-1:0]     base_addr;
    logic [LW-1:0]     length;
    logic              s_valid;
    logic [DW-1:0]     s_data;
    logic              s_last;
    logic              s_ready, busy, done, err_last;
    logic [NS-1:0]     sram_en, sram_we;
    logic [NS*AW-1:0]  sram_addr;
    logic [NS*DW-1:0]  sram_data;

    sram_stream_loader #(
        .NUM_SRAMS(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bank_sel(bank_sel),
        .base_addr(base_addr), .length(length), .s_valid(s_valid),
        .s_data(s_data), .s_last(s_last), .s_ready(s_ready), .busy(busy),
        .done(done), .err_last(err_last), .sram_en(sram_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_data(sram_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [2:0]    bank;
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        bit            toggle;
        int            last_pos;
        bit            exp_err;
    } vec_t;

    wr_t        exp_q[$];
    vec_t       vecs[7];
    int         total = 0;
    int         bad = 0;
    int         strobes, dones, m_sent;
    logic [1:0] m_state;
    logic [2:0] m_bank;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_cnt;
    logic       m_err;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Advance the reference model on the driven inputs, clock once, compare all outputs.
    task automatic cycle();
        bit               acc;
        wr_t              w;
        logic [NS-1:0]    e_en;
        logic [NS*AW-1:0] e_addr;
        logic [NS*DW-1:0] e_data;
        acc = 1'b0;
        if (rst) begin
            m_state = 2'd0; m_cnt = '0; m_err = 1'b0; m_addr = '0; m_bank = '0;
            exp_q.delete();
        end else begin
            case (m_state)
                2'd0: if (start) begin
                    m_bank = bank_sel; m_addr = base_addr; m_cnt = length; m_err = 1'b0;
                    m_state = (length == 14'd0) ? 2'd2 : 2'd1;
                end
                2'd1: if (s_valid && m_cnt != 14'd0) begin
                    acc = 1'b1;
                    exp_q.push_back('{m_bank, m_addr, s_data});
                    if (s_last != (m_cnt == 14'd1)) m_err = 1'b1;
                    if (m_cnt == 14'd1) m_state = 2'd2;
                    m_cnt = m_cnt - 14'd1;
                    m_addr = m_addr + 13'd1;
                    m_sent++;
                end
                default: m_state = 2'd0;
            endcase
        end
        @(posedge clk);
        #1;
        check("busy", busy, m_state != 2'd0);
        check("done", done, m_state == 2'd2);
        check("s_ready", s_ready, (m_state == 2'd1) && (m_cnt != 14'd0));
        check("err_last", err_last, m_err);
        e_en = '0; e_addr = '0; e_data = '0;
        if (acc) begin
            w = exp_q.pop_front();
            e_en[w.bank] = 1'b1;
            e_addr[int'(w.bank)*AW +: AW] = w.addr;
            e_data[int'(w.bank)*DW +: DW] = w.data;
        end
        check("sram_en", sram_en, e_en);
        check("sram_we", sram_we, e_en);
        check("sram_addr", sram_addr, e_addr);
        check("sram_data", sram_data, e_data);
        if (sram_we != '0) strobes++;
        if (done) dones++;
    endtask

    task automatic issue_start(input logic [2:0] bank, input logic [AW-1:0] base, input logic [LW-1:0] len);
        strobes = 0; dones = 0; m_sent = 0;
        start = 1'b1; bank_sel = bank; base_addr = base; length = len;
        s_valid = 1'b0; s_last = 1'b0;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_xfer(input vec_t v, input string tag);
        int guard;
        issue_start(v.bank, v.base, v.len);
        guard = 0;
        while (m_state != 2'd0 && guard < 4 * int'(v.len) + 8) begin
            s_valid = v.toggle ? (guard % 2 == 0) : 1'b1;
            s_data  = {$urandom, $urandom};
            s_last  = s_valid && (m_sent + 1 == v.last_pos);
            cycle();
            guard++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        check({tag, " idle_at_end"}, busy, 1'b0);
        check({tag, " strobe_count"}, strobes, v.len);
        check({tag, " done_pulses"}, dones, 1);
        check({tag, " err_final"}, err_last, v.exp_err);
    endtask

    initial begin
        vecs[0] = '{3'd2, 13'd100,  14'd4, 1'b0, 4, 1'b0};
        vecs[1] = '{3'd2, 13'd100,  14'd4, 1'b1, 4, 1'b0};
        vecs[2] = '{3'd7, 13'd8190, 14'd3, 1'b0, 3, 1'b0};
        vecs[3] = '{3'd0, 13'd55,   14'd0, 1'b0, 0, 1'b0};
        vecs[4] = '{3'd5, 13'd20,   14'd3, 1'b0, 2, 1'b1};
        vecs[5] = '{3'd3, 13'd7,    14'd2, 1'b1, 0, 1'b1};
        vecs[6] = '{3'd1, 13'd50,   14'd5, 1'b0, 5, 1'b0};

        rst = 1'b1; start = 1'b0; bank_sel = '0; base_addr = '0; length = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_sent = 0;
        strobes = 0; dones = 0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i], $sformatf("vec%0d", i));
            cycle();
        end

        // wrap check independent of the model: third strobe of bank 7 lands at address 0
        issue_start(3'd7, 13'd8190, 14'd3);
        s_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            s_data = 64'hA5A5_0000_0000_0000 | 64'(b); s_last = (b == 2);
            cycle();
        end
        s_valid = 1'b0;
        check("wrap_addr", sram_addr[7*AW +: AW], 13'd0);
        check("wrap_data", sram_data[7*DW +: DW], 64'hA5A5_0000_0000_0002);
        cycle();
        cycle();

        // start pulsed while busy must be ignored
        issue_start(3'd6, 13'd40, 14'd3);
        for (int b = 0; b < 3; b++) begin
            s_valid = 1'b1; s_data = {$urandom, $urandom}; s_last = (b == 2);
            start = (b == 1); bank_sel = 3'd0; length = 14'd9;
            cycle();
        end
        start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        cycle();
        cycle();
        check("busy_start strobes", strobes, 3);
        check("busy_start idle", busy, 1'b0);

        // reset after two of five beats, beat in the reset cycle must not strobe
        issue_start(3'd4, 13'd300, 14'd5);
        for (int b = 0; b < 2; b++) begin
            s_valid = 1'b1; s_data = {$urandom, $urandom};
            cycle();
        end
        rst = 1'b1; s_data = {$urandom, $urandom};
        cycle();
        check("rst_mid we", sram_we, '0);
        check("rst_mid busy", busy, 1'b0);
        rst = 1'b0; s_valid = 1'b0;
        cycle();
        check("rst_mid strobes", strobes, 2);
        run_xfer('{3'd4, 13'd300, 14'd5, 1'b0, 5, 1'b0}, "post_rst");
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_stream_loader.md
# sram_stream_loader

Write-side front end for the multi-bank activation/weight SRAM array. It accepts a valid/ready stream of 64-bit words and a per-transfer command (bank, base address, length). It then drives packed per-bank enable, write-enable, address and data buses that connect directly to the bank array's `en`, `we`, `addr` and `data_in` inputs. Exactly one bank is written per transfer, one word per cycle at full throughput.

## Interface

Parameters:
- `NUM_SRAMS`, default 8: number of banks. Sets packed bus widths.
- `ADDR_WIDTH`, default 13: per-bank address width. Matches the array's `MAX_ADDR_WIDTH`.
- `DATA_WIDTH`, default 64: word width.
- `LEN_WIDTH`, default 14: transfer length width, in words.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset. Synchronous, active-high.
- `start`, in, 1: command strobe. Sampled only in IDLE.
- `bank_sel`, in, `$clog2(NUM_SRAMS)`: target bank. Latched on `start`.
- `base_addr`, in, `ADDR_WIDTH`: first write address. Latched on `start`.
- `length`, in, `LEN_WIDTH`: number of words to write. Latched on `start`.
- `s_valid`, in, 1: input word valid.
- `s_data`, in, `DATA_WIDTH`: input word.
- `s_last`, in, 1: producer's end-of-transfer marker.
- `s_ready`, out, 1: loader accepts the word this cycle.
- `busy`, out, 1: a transfer is in progress.
- `done`, out, 1: one-cycle completion pulse.
- `err_last`, out, 1: sticky flag for an `s_last`/length mismatch.
- `sram_en`, out, `NUM_SRAMS`: per-bank enable.
- `sram_we`, out, `NUM_SRAMS`: per-bank write enable.
- `sram_addr`, out, `NUM_SRAMS*ADDR_WIDTH`: packed addresses. Bank i occupies `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `sram_data`, out, `NUM_SRAMS*DATA_WIDTH`: packed write data. Bank i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.

## Operation

- FSM states: IDLE, WRITE, DONE.
- IDLE, `start`=1:
  - Latch `bank_sel`, `base_addr` and `length`.
  - Clear `err_last`.
  - Go to WRITE if `length`≠0. Go to DONE if `length`=0; no SRAM access occurs.
- IDLE, `start`=0: remain in IDLE.
- `start` in WRITE or DONE is ignored. No queuing.
- WRITE:
  - `s_ready` = (remaining count ≠ 0). It is combinational from state and counter only, never from `s_valid`.
  - A beat is accepted when `s_valid`&`s_ready`.
  - Each accepted beat decrements the remaining count and increments the write address.
  - The address wraps modulo 2^`ADDR_WIDTH`; 8191 is followed by 0.
  - When the final beat (remaining = 1) is accepted, go to DONE.
- DONE: `done`=1 for exactly one cycle, then return to IDLE.
- `err_last` is set, and stays set until the next accepted `start`, when either:
  - `s_last`=1 on an accepted non-final beat, or
  - `s_last`=0 on the accepted final beat.
- The transfer always runs to exactly `length` words regardless of `s_last`.
- SRAM outputs are registered:
  - For each accepted beat, the next cycle has `sram_en[bank]`=`sram_we[bank]`=1 and the bank's address and data slices set to that beat's address and word.
  - All other bits of `sram_en` and `sram_we` are 0. All non-selected address and data slices are 0.
  - With no accepted beat, `sram_en`=`sram_we`=0 and the address and data slices hold 0.
- Bubbles (`s_valid`=0) produce no write and do not advance the address.

## Timing

- Reset values: state IDLE, `s_ready`=0, `busy`=0, `done`=0, `err_last`=0, `sram_en`=0, `sram_we`=0, `sram_addr`=0, `sram_data`=0, counters 0.
- Reset mid-transfer: the outputs above apply on the next edge, and no write strobe is emitted for a beat accepted in the reset cycle.
- Start latency: `start` at cycle T gives `busy`=1 and `s_ready`=1 at T+1.
- Write latency: a beat accepted at cycle C appears on the SRAM buses at C+1.
- Throughput: one word per cycle with `s_valid` held high. An N-word transfer started at T accepts beats at T+1…T+N.
- Completion, final beat accepted at cycle F:
  - DONE at F+1. `done`=1 in the same cycle as the last write strobe.
  - `busy`=0 and IDLE at F+2.
  - The earliest next `start` is sampled at F+2.
- Zero length: `start` at T gives `done`=1 at T+1, with `busy`=1 for that cycle only.
- `busy` = (state ≠ IDLE).

## Test plan

- Bank 2, base 100, length 4, continuous `s_valid`, words A0..A3, `s_last` on the 4th beat:
  - `sram_we`=0x04 for 4 consecutive cycles at addresses 100..103 with data A0..A3.
  - `done` coincides with the 4th strobe. `err_last`=0.
- Same command with `s_valid` toggling 1,0,1,0…: exactly 4 strobes, none during bubble cycles, addresses contiguous.
- Bank 7, base 8190, length 3: addresses 8190, 8191, 0.
- Length 0 → `done` one cycle after `start`, no strobes, `s_ready` never asserts.
- Length 3 with `s_last` on beat 2 → `err_last`=1 and 3 writes still occur. A subsequent `start` clears `err_last`.
- Reset asserted after 2 of 5 beats → all outputs 0 on the next edge and the FSM in IDLE. A new `start` after reset runs a full, correct transfer. A `start` pulsed while `busy` is ignored.
